// File: rtl/ddr_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_cmd_arbiter
//   Shares one DDR controller command interface between NUM_REQ requesters.
//   Every requester owns two pending slots: slot 2i holds its write and slot
//   2i+1 holds its read. A one-cycle start pulse loads a slot. Pending slots
//   are granted round-robin, and only one DDR command is outstanding at a time.
//   The controller's done, and any read data, is routed back to the requester
//   that issued the command. A watchdog forces completion if the controller
//   never answers.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_wr_start/addr/data      per-requester write pulse plus payload (packed)
//   req_rd_start/addr           per-requester read pulse plus address (packed)
//   req_wr_done/req_rd_done     one-cycle completion pulse per requester
//   req_rd_data                 read data of the most recent read completion
//   ddr_wr_*/ddr_rd_*           controller command/response interface
//   busy                        a command is being issued or awaited
//   overflow_err, timeout_err   sticky error flags, cleared by err_clr
// ----------------------------------------------------------------------------
module ddr_cmd_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 256,
   parameter int TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_wr_start,
   input  logic [NUM_REQ*ADDR_W-1:0] req_wr_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
   input  logic [NUM_REQ-1:0]        req_rd_start,
   input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
   output logic [NUM_REQ-1:0]        req_wr_done,
   output logic [NUM_REQ-1:0]        req_rd_done,
   output logic [DATA_W-1:0]         req_rd_data,
   output logic                      ddr_wr_start,
   output logic [ADDR_W-1:0]         ddr_wr_addr,
   output logic [DATA_W-1:0]         ddr_wr_data,
   input  logic                      ddr_wr_done,
   output logic                      ddr_rd_start,
   output logic [ADDR_W-1:0]         ddr_rd_addr,
   input  logic                      ddr_rd_done,
   input  logic [DATA_W-1:0]         ddr_rd_data,
   output logic                      busy,
   output logic                      overflow_err,
   output logic                      timeout_err,
   input  logic                      err_clr
);

   localparam int NUM_SLOT = 2 * NUM_REQ;
   localparam int SLOT_W   = $clog2(NUM_SLOT);
   localparam int CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [SLOT_W:0]  NUM_SLOT_L = NUM_SLOT[SLOT_W:0];
   localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t              state, state_nxt;
   logic [NUM_SLOT-1:0] pend;
   logic [ADDR_W-1:0]   slot_addr [NUM_SLOT];
   logic [DATA_W-1:0]   slot_data [NUM_REQ];
   logic [SLOT_W-1:0]   rr_ptr, gnt_slot;
   logic [CNT_W-1:0]    wd_cnt;

   logic [NUM_SLOT-1:0] start_vec, pend_rot, gnt_mask;
   logic [ADDR_W-1:0]   start_addr [NUM_SLOT];
   logic [SLOT_W-1:0]   pick_off, pick_slot;
   logic [SLOT_W:0]     pick_sum;
   logic                pick_vld;
   logic [ADDR_W-1:0]   pick_addr;
   logic [DATA_W-1:0]   pick_data;
   logic [NUM_REQ-1:0]  wr_sel, rd_sel;
   logic                grant, done_hit, wd_fire, finish, overflow_hit;

   // Flatten the requester ports into slot order.
   always_comb begin
      start_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         start_vec[2*i]    = req_wr_start[i];
         start_vec[2*i+1]  = req_rd_start[i];
         start_addr[2*i]   = req_wr_addr[i*ADDR_W +: ADDR_W];
         start_addr[2*i+1] = req_rd_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Round-robin pick: rotate pending so that rr_ptr lands at bit 0, take the
   // lowest set bit, then rotate the offset back into a slot number.
   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      pick_vld  = 1'b0;
      pick_off  = '0;
      pick_addr = '0;
      pick_data = '0;
      pend_rot  = NUM_SLOT'({pend, pend} >> rr_ptr);
      for (int k = NUM_SLOT - 1; k >= 0; k--) begin
         if (pend_rot[k]) begin
            pick_vld = 1'b1;
            pick_off = SLOT_W'(k);
         end
      end
      pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
      if (pick_sum >= NUM_SLOT_L) pick_sum = pick_sum - NUM_SLOT_L;
      pick_slot = pick_sum[SLOT_W-1:0];
      for (int s = 0; s < NUM_SLOT; s++)
         if (pick_slot == SLOT_W'(s)) pick_addr = slot_addr[s];
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_slot == SLOT_W'(2*i)) pick_data = slot_data[i];
   end

   // One-hot decodes of the slot being granted and of the slot in flight.
   always_comb begin
      gnt_mask = '0;
      wr_sel   = '0;
      rd_sel   = '0;
      for (int s = 0; s < NUM_SLOT; s++)
         gnt_mask[s] = grant && (pick_slot == SLOT_W'(s));
      for (int i = 0; i < NUM_REQ; i++) begin
         wr_sel[i] = (gnt_slot == SLOT_W'(2*i));
         rd_sel[i] = (gnt_slot == SLOT_W'(2*i+1));
      end
   end

   // A pulse into the slot that is granted on this same edge simply re-arms
   // it; that is a new request, not an overflow.
   assign overflow_hit = |(start_vec & pend & ~gnt_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done_hit  = 1'b0;
      wd_fire   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_vld) begin
               grant     = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            // Only the done of the granted command type counts.
            done_hit = gnt_slot[0] ? ddr_rd_done : ddr_wr_done;
            wd_fire  = !done_hit && (wd_cnt == WD_LAST);
            if (done_hit || wd_fire) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign finish = done_hit | wd_fire;
   assign busy   = (state != ST_IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values no matter how the statements are
   // ordered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the slot storage is cleared explicitly as well, so that a
         // freshly reset part never shows a stale address on ddr_*_addr.
         pend <= '0;
         for (int s = 0; s < NUM_SLOT; s++) slot_addr[s] <= '0;
         for (int i = 0; i < NUM_REQ; i++)  slot_data[i] <= '0;
         rr_ptr       <= '0;
         gnt_slot     <= '0;
         wd_cnt       <= '0;
         ddr_wr_start <= 1'b0;
         ddr_rd_start <= 1'b0;
         ddr_wr_addr  <= '0;
         ddr_wr_data  <= '0;
         ddr_rd_addr  <= '0;
         req_wr_done  <= '0;
         req_rd_done  <= '0;
         req_rd_data  <= '0;
         overflow_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         ddr_wr_start <= 1'b0;
         ddr_rd_start <= 1'b0;
         req_wr_done  <= '0;
         req_rd_done  <= '0;

         pend <= (pend & ~gnt_mask) | start_vec;
         for (int s = 0; s < NUM_SLOT; s++)
            if (start_vec[s]) slot_addr[s] <= start_addr[s];
         for (int i = 0; i < NUM_REQ; i++)
            if (req_wr_start[i]) slot_data[i] <= req_wr_data[i*DATA_W +: DATA_W];

         // The start pulse is registered on the grant edge, so it is high for
         // exactly the ISSUE cycle.
         if (grant) begin
            gnt_slot <= pick_slot;
            if (pick_slot[0]) begin
               ddr_rd_start <= 1'b1;
               ddr_rd_addr  <= pick_addr;
            end else begin
               ddr_wr_start <= 1'b1;
               ddr_wr_addr  <= pick_addr;
               ddr_wr_data  <= pick_data;
            end
         end

         if (state == ST_ISSUE)     wd_cnt <= '0;
         else if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;

         if (finish) begin
            req_wr_done <= wr_sel;
            req_rd_done <= rd_sel;
            if (gnt_slot[0]) req_rd_data <= done_hit ? ddr_rd_data : '0;
            rr_ptr <= (gnt_slot == SLOT_W'(NUM_SLOT - 1)) ? '0 : gnt_slot + 1'b1;
         end

         if (err_clr) begin
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
         end else begin
            if (overflow_hit) overflow_err <= 1'b1;
            if (wd_fire)      timeout_err  <= 1'b1;
         end
      end
   end

endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
Shares the single DDR controller command interface between NUM_REQ clock-domain requesters. Each requester is typically one async-to-sync bridge instance emitting one-cycle write/read start pulses.
- Captures each pulse into a per-requester pending slot.
- Grants slots round-robin and issues exactly one outstanding DDR command at a time.
- Routes the controller's done, and read data, back to the originating requester.
- Includes a completion watchdog so a hung controller cannot deadlock the bridges.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
ADDR_W, 32, address width
DATA_W, 256, data beat width
TIMEOUT, 1023, max cycles waiting for controller done before forced completion (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_wr_start  in  NUM_REQ  per-requester write pulse
req_wr_addr  in  NUM_REQ*ADDR_W  write address, requester i at [i*ADDR_W +: ADDR_W]
req_wr_data  in  NUM_REQ*DATA_W  write data, same packing
req_rd_start  in  NUM_REQ  per-requester read pulse
req_rd_addr  in  NUM_REQ*ADDR_W  read address
req_wr_done  out  NUM_REQ  one-cycle write-complete pulse to requester i
req_rd_done  out  NUM_REQ  one-cycle read-complete pulse to requester i
req_rd_data  out  DATA_W  read data, valid in req_rd_done cycle, held until next read completion
ddr_wr_start  out  1  one-cycle write command pulse
ddr_wr_addr  out  ADDR_W  write address, held from issue through completion
ddr_wr_data  out  DATA_W  write data, held from issue through completion
ddr_wr_done  in  1  controller write complete
ddr_rd_start  out  1  one-cycle read command pulse
ddr_rd_addr  out  ADDR_W  read address, held from issue through completion
ddr_rd_done  in  1  controller read complete
ddr_rd_data  in  DATA_W  read data, valid with ddr_rd_done
busy  out  1  high in ISSUE/WAIT
overflow_err  out  1  sticky: start pulse hit an already-pending slot
timeout_err  out  1  sticky: watchdog fired
err_clr  in  1  clears both sticky flags

Behaviour:
Reset
- Reset is asynchronous, active-low (rst_n). Clock is clk.
- On reset, every output, every slot, the FSM, rr_ptr and the watchdog counter go to 0/IDLE.
- Reset mid-command abandons the command silently; no done pulse is issued.

Slots
- 2*NUM_REQ slots: slot 2i = write of requester i, slot 2i+1 = read of requester i.
- Each slot holds a pending bit plus latched addr (and data for writes).
- A start pulse sets pending and latches the inputs in the same edge.
- Pulse on an already-pending slot: contents are overwritten with the newest request, and overflow_err is set.

FSM IDLE -> ISSUE -> WAIT -> IDLE
- IDLE: if any slot is pending, grant the first pending slot at or after rr_ptr, scanning upward with wrap modulo 2*NUM_REQ.
  - The granted slot's contents move to the ddr_* address/data registers.
  - The granted slot's pending bit clears.
- A pulse arriving in the grant cycle for that same slot re-sets pending with the new contents and does not set overflow_err.
- ISSUE: exactly one cycle. ddr_wr_start or ddr_rd_start is high for this cycle according to slot type. The watchdog counter clears.
- WAIT: the counter increments each cycle. On the done matching the granted type:
  - Pulse req_wr_done[i] or req_rd_done[i] the next cycle.
  - For reads, register ddr_rd_data into req_rd_data in the same edge.
  - rr_ptr = grant+1 mod 2*NUM_REQ; return to IDLE.
- Timeout: counter reaching TIMEOUT without done:
  - Set timeout_err.
  - Issue the requester done pulse anyway; for reads, req_rd_data = 0.
  - Advance rr_ptr and go to IDLE.
- Done signals in IDLE/ISSUE, or of the non-granted type, are ignored.

Latency and throughput
- Latency, idle arbiter: req pulse at edge k -> grant at edge k+1 -> ddr start high during cycle after edge k+2.
- ddr done at edge m -> requester done high after edge m+1.
- Minimum spacing between consecutive ddr starts is 3 cycles.

Error flags
- err_clr has priority over a same-cycle set.
- At most one ddr_*_start is ever high, and never while busy from a prior command.

Test Plan:
- Single write, req 0, addr 0x100, controller done 5 cycles after start -> ddr_wr_start 2 cycles after pulse with addr 0x100, req_wr_done[0] 1 cycle after done, busy low next cycle.
- Read, req 1, ddr_rd_data = 0xA5..A5 -> req_rd_done[1] pulse, req_rd_data = 0xA5..A5 held through later writes.
- Same-cycle write pulses from req 0 and req 1 with rr_ptr = 0 -> served in order req0 then req1; next simultaneous pair with rr_ptr = 3 -> order: req0 write (slot 0) then req1 write (slot 2).
- Second write pulse on pending slot 0 before grant -> only the second address is issued, overflow_err = 1; err_clr -> overflow_err = 0.
- TIMEOUT = 8, no done -> timeout_err = 1 after 8 WAIT cycles, requester done pulse still issued, next pending slot then serviced.
- rst_n low during WAIT -> all outputs 0 immediately, no done pulse; late ddr_wr_done after reset is ignored.
